// File: rtl/spi_read_adc.sv
// SPI mode-0 master receive channel: on a start request it drops CS, clocks Width bits
// in from MISO MSB first at a programmable SCK rate, then presents the word with a one-cycle pulse.
module spi_read_adc #(
  parameter int Width  = 16,
  parameter int KWidth = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              strr_i,
  input  logic [KWidth-1:0] kmax_i,
  input  logic              miso_i,
  output logic              sck_o,
  output logic              cs_o,
  output logic [Width-1:0]  dout_o,
  output logic              eor_o,
  output logic              busy_o
);
  localparam int CW = $clog2(Width + 1);

  typedef enum logic [1:0] {IDLE, LOW, HIGH, STOP} state_t;

  state_t            state;
  logic [KWidth-1:0] kmax_q;
  logic [KWidth-1:0] div;
  logic [CW-1:0]     bitcnt;
  logic [Width-1:0]  shift;
  logic              tick;

  // One tick per SCK half-period; the divider restarts from 0 on the accepting edge.
  assign tick = (div == kmax_q);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state  <= IDLE;
      kmax_q <= '0;
      div    <= '0;
      bitcnt <= '0;
      shift  <= '0;
      cs_o   <= 1'b1;
      sck_o  <= 1'b0;
      eor_o  <= 1'b0;
      busy_o <= 1'b0;
      dout_o <= '0;
    end else begin
      eor_o <= 1'b0;
      if (state == IDLE || tick) div <= '0;
      else                       div <= div + 1'b1;
      case (state)
        IDLE: if (strr_i) begin
          kmax_q <= kmax_i;
          bitcnt <= '0;
          cs_o   <= 1'b0;
          busy_o <= 1'b1;
          state  <= LOW;
        end
        // MISO is sampled on the same edge that raises SCK.
        LOW: if (tick) begin
          shift <= {shift[Width-2:0], miso_i};
          sck_o <= 1'b1;
          state <= HIGH;
        end
        HIGH: if (tick) begin
          sck_o  <= 1'b0;
          bitcnt <= bitcnt + 1'b1;
          state  <= (bitcnt == CW'(Width - 1)) ? STOP : LOW;
        end
        // Extra half-period with CS still low gives the ADC its hold time.
        STOP: if (tick) begin
          cs_o   <= 1'b1;
          dout_o <= shift;
          eor_o  <= 1'b1;
          busy_o <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_spi_read_adc.sv
// Scoreboard bench for spi_read_adc: mode-0 ADC models feed a 16-bit and a 12-bit instance;
// a monitor pops expected words/timing whenever eor_o pulses.
module tb_spi_read_adc;
  logic clk = 1'b0;
  logic rst_i = 1'b0;
  logic [7:0] kmax = '0;
  logic strr16 = 1'b0, strr12 = 1'b0;
  logic miso16 = 1'b0, miso12 = 1'b0;
  logic sck16, cs16, eor16, busy16, sck12, cs12, eor12, busy12;
  logic [15:0] dout16;
  logic [11:0] dout12;

  always #5 clk = ~clk;

  spi_read_adc #(.Width(16), .KWidth(8)) dut16 (
    .clk_i(clk), .rst_i(rst_i), .strr_i(strr16), .kmax_i(kmax), .miso_i(miso16),
    .sck_o(sck16), .cs_o(cs16), .dout_o(dout16), .eor_o(eor16), .busy_o(busy16));

  spi_read_adc #(.Width(12), .KWidth(8)) dut12 (
    .clk_i(clk), .rst_i(rst_i), .strr_i(strr12), .kmax_i(kmax), .miso_i(miso12),
    .sck_o(sck12), .cs_o(cs12), .dout_o(dout12), .eor_o(eor12), .busy_o(busy12));

  int checks = 0, errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // ADC models: first bit appears on CS fall, next bit after each SCK fall
  logic [15:0] q16[$];
  logic [11:0] q12[$];
  logic [15:0] cur16 = '0;
  logic [11:0] cur12 = '0;
  int idx16 = 0, idx12 = 0;
  always @(negedge cs16) begin
    cur16 = (q16.size() > 0) ? q16.pop_front() : 16'h0;
    idx16 = 15; miso16 = cur16[15];
  end
  always @(negedge sck16) if (!cs16 && idx16 > 0) begin idx16--; miso16 = cur16[idx16]; end
  always @(negedge cs12) begin
    cur12 = (q12.size() > 0) ? q12.pop_front() : 12'h0;
    idx12 = 11; miso12 = cur12[11];
  end
  always @(negedge sck12) if (!cs12 && idx12 > 0) begin idx12--; miso12 = cur12[idx12]; end

  typedef struct {
    logic [15:0] dout;
    int lat;    // cycles from CS fall to eor (= CS low time)
    int rises;
    int h;      // SCK high width in clk cycles
    int gap;    // CS high cycles before this transaction, -1 = don't care
  } exp_t;
  exp_t sb[$];

  // Monitor observes whichever instance sel points at
  logic sel = 1'b0;
  logic m_sck, m_cs, m_eor, m_busy;
  logic [15:0] m_dout;
  assign m_sck  = sel ? sck12 : sck16;
  assign m_cs   = sel ? cs12 : cs16;
  assign m_eor  = sel ? eor12 : eor16;
  assign m_busy = sel ? busy12 : busy16;
  assign m_dout = sel ? {4'h0, dout12} : dout16;

  logic ps = 1'b0, pcs = 1'b1, after_eor = 1'b0;
  int t0 = 0, rises = 0, hrun = 0, hmin = 0, hmax = 0, crun = 0, gap = 0, done_cnt = 0;

  always @(negedge clk) begin
    if (!rst_i) begin
      ps = 1'b0; pcs = 1'b1; after_eor = 1'b0; crun = 0; rises = 0;
    end else begin
      if (after_eor) begin chk("eor_one_cycle", m_eor, 1'b0); after_eor = 1'b0; end
      if (pcs && !m_cs) begin
        t0 = cyc; rises = 0; hmin = 1000000; hmax = 0; gap = crun;
      end
      crun = m_cs ? crun + 1 : 0;
      if (m_sck) begin
        if (!ps) rises++;
        hrun = ps ? hrun + 1 : 1;
      end else if (ps) begin
        if (hrun < hmin) hmin = hrun;
        if (hrun > hmax) hmax = hrun;
      end
      if (m_eor && !m_cs) chk("cs_high_at_eor", m_cs, 1'b1);
      if (m_eor) begin
        exp_t e;
        done_cnt++;
        after_eor = 1'b1;
        if (sb.size() == 0) chk("unexpected_eor", 1'b1, 1'b0);
        else begin
          e = sb.pop_front();
          chk("dout", m_dout, e.dout);
          chk("latency", cyc - t0, e.lat);
          chk("sck_rises", rises, e.rises);
          chk("sck_high_min", hmin, e.h);
          chk("sck_high_max", hmax, e.h);
          chk("busy_at_eor", m_busy, 1'b0);
          if (e.gap >= 0) chk("cs_high_gap", gap, e.gap);
        end
      end
      ps = m_sck; pcs = m_cs;
    end
  end

  task automatic start(input logic [7:0] k, input logic w12);
    @(posedge clk); #1;
    kmax = k;
    if (w12) strr12 = 1'b1; else strr16 = 1'b1;
    @(posedge clk); #1;
    strr12 = 1'b0; strr16 = 1'b0;
  endtask

  task automatic wait_done(input int target);
    int n = 0;
    while (done_cnt < target && n < 3000) begin @(posedge clk); n++; end
    if (done_cnt < target) chk("eor_timeout", done_cnt, target);
  endtask

  initial begin
    int base;
    #12;
    chk("rst_cs", cs16, 1'b1);
    chk("rst_sck", sck16, 1'b0);
    chk("rst_eor", eor16, 1'b0);
    chk("rst_busy", busy16, 1'b0);
    chk("rst_dout", dout16, 16'h0);
    @(posedge clk); #1 rst_i = 1'b1;

    // Reset abort after 5 SCK rises (kmax=0: rises at E0+1,3,5,7,9)
    q16.push_back(16'hA5C3);
    start(8'd0, 1'b0);
    repeat (9) @(posedge clk);
    #1 chk("abort_sck_before", sck16, 1'b1);
    rst_i = 1'b0;
    #1;
    chk("abort_cs", cs16, 1'b1);
    chk("abort_sck", sck16, 1'b0);
    chk("abort_busy", busy16, 1'b0);
    chk("abort_eor", eor16, 1'b0);
    chk("abort_dout", dout16, 16'h0);
    #3 rst_i = 1'b1;
    base = done_cnt;
    repeat (60) @(posedge clk);
    chk("abort_no_eor", done_cnt, base);

    // Basic read, H=1: latency 2*16+1
    q16.push_back(16'hA5C3);
    sb.push_back('{16'hA5C3, 33, 16, 1, -1});
    start(8'd0, 1'b0);
    wait_done(base + 1);

    // Slow clock, H=5: latency 33*5
    q16.push_back(16'h8001);
    sb.push_back('{16'h8001, 165, 16, 5, -1});
    start(8'd4, 1'b0);
    wait_done(base + 2);

    // Busy protection: restart request and kmax change ignored, H stays 3
    q16.push_back(16'h1234);
    sb.push_back('{16'h1234, 99, 16, 3, -1});
    start(8'd2, 1'b0);
    repeat (20) @(posedge clk);
    #1 kmax = 8'd7; strr16 = 1'b1;
    @(posedge clk); #1 strr16 = 1'b0;
    wait_done(base + 3);
    repeat (200) @(posedge clk);
    chk("busy_single_eor", done_cnt, base + 3);
    chk("busy_idle_after", busy16, 1'b0);

    // Back-to-back with strr held: one CS-high cycle between words
    q16.push_back(16'hFFFF);
    q16.push_back(16'h0000);
    sb.push_back('{16'hFFFF, 33, 16, 1, -1});
    sb.push_back('{16'h0000, 33, 16, 1, 1});
    @(posedge clk); #1 kmax = 8'd0; strr16 = 1'b1;
    wait_done(base + 4);
    @(posedge clk); #1 strr16 = 1'b0;
    wait_done(base + 5);
    chk("b2b_dout_hold", dout16, 16'h0000);

    // Width=12, H=2: latency 25*2
    repeat (5) @(posedge clk);
    sel = 1'b1;
    q12.push_back(12'hABC);
    sb.push_back('{16'h0ABC, 50, 12, 2, -1});
    start(8'd1, 1'b1);
    wait_done(base + 6);
    repeat (5) @(posedge clk);
    chk("w12_dout_hold", dout12, 12'hABC);
    chk("sb_drained", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
